// File: rtl/uart_tx_result.sv
// uart_tx_result: multi-byte 8N1 UART transmitter, least-significant byte first.
// Define UART_TX_PARITY_EN to append an even-parity bit after data bit 7 of every frame.
`timescale 1ns/1ps
module uart_tx_result #(
   parameter int CLKS_PER_BIT = 500,
   parameter int DATA_BYTES   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8*DATA_BYTES-1:0] data,
   output logic                    busy,
   output logic                    done,
   output logic                    tx
);
   localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int YW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [YW-1:0] BYTE_LAST = YW'(DATA_BYTES - 1);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [YW-1:0] byte_q, byte_d;
   logic [8*DATA_BYTES-1:0] shift_q, shift_d;
   logic [7:0] cur_d;
   logic tx_q, tx_d, busy_q, done_q, done_d, tick;
   assign tick = baud_q == BAUD_LAST;
   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
   always_comb begin
      state_d = state_q;
      baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            shift_d = data;
            byte_d  = '0;
            state_d = START;
         end
         START: if (tick) begin
            bit_d   = '0;
            state_d = DATA;
         end
         DATA: if (tick) begin
            bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_q == 3'd7) state_d = PARITY;
`else
            if (bit_q == 3'd7) state_d = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) state_d = STOP;
`endif
         STOP: if (tick) begin
            if (byte_q != BYTE_LAST) begin
               byte_d  = byte_q + 1'b1;
               shift_d = shift_q >> 8;
               state_d = START;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // tx is computed from the next state so the registered line changes on the bit boundary itself
      cur_d = shift_d[7:0];
`ifdef UART_TX_PARITY_EN
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? cur_d[bit_d] : state_d == PARITY ? ^cur_d : 1'b1;
`else
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? cur_d[bit_d] : 1'b1;
`endif
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= state_d != IDLE;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_result.sv
// tb_uart_tx_result: randomized and directed checks of uart_tx_result against a
// per-cycle waveform model built from the frame format (start, 8 data LSB first, [parity], stop).
`timescale 1ns/1ps
module tb_uart_tx_result;
   localparam int C  = 4;
   localparam int NB = 3;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int W = NB * FB * C;

   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [8*NB-1:0] data = '0;
   logic busy, done, tx;
   int ncmp = 0, nfail = 0;

   uart_tx_result #(.CLKS_PER_BIT(C), .DATA_BYTES(NB)) dut (
      .clk(clk), .reset(reset), .start(start), .data(data),
      .busy(busy), .done(done), .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends word d and checks tx/busy/done on every cycle from the start bit through the done cycle.
   task automatic run_word(input logic [23:0] d, input bit hold, input int spur_at,
                           input logic [23:0] spur_d, input bit scramble, input int abort_at,
                           input string name);
      logic q[$];
      logic [7:0] b;
      logic exp_tx;
      for (int i = 0; i < NB; i++) begin
         b = d[8*i +: 8];
         for (int r = 0; r < C; r++) q.push_back(1'b0);
         for (int k = 0; k < 8; k++) for (int r = 0; r < C; r++) q.push_back(b[k]);
         if (FB == 11) for (int r = 0; r < C; r++) q.push_back(^b);
         for (int r = 0; r < C; r++) q.push_back(1'b1);
      end
      start = 1'b1;
      data  = d;
      step();
      if (!hold) start = 1'b0;
      for (int k = 0; k <= W; k++) begin
         if (k == abort_at) return;
         exp_tx = k < W ? q[k] : 1'b1;
         ncmp++;
         if (tx !== exp_tx || busy !== (k < W) || done !== (k == W)) begin
            nfail++;
            $display("FAIL %s cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=%b done=%b",
                     name, k, tx, busy, done, exp_tx, k < W, k == W);
         end
         if (k == spur_at) begin
            start = 1'b1;
            data  = spur_d;
         end else if (!hold) start = 1'b0;
         if (scramble) data = 24'($urandom());
         if (k < W) step();
      end
   endtask

   task automatic check_idle(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         ncmp++;
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            nfail++;
            $display("FAIL %s idle %0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
                     name, i, tx, busy, done);
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      check_idle(3, "reset_active");
      reset = 1'b0;
      check_idle(10, "post_reset");
   endtask

   task automatic test_single();
      run_word(24'h123456, 1'b0, -1, '0, 1'b0, -1, "single");
      step();
      check_idle(3, "single_after");
   endtask

   task automatic test_ignored_start();
      run_word(24'hA5A5A5, 1'b0, 50, 24'hFFFFFF, 1'b0, -1, "ignored_start");
      step();
      check_idle(5, "ignored_after");
   endtask

   task automatic test_reset_mid();
      run_word(24'hABCDEF, 1'b0, -1, '0, 1'b0, FB * C + 20, "reset_mid");
      ncmp++;
      if (tx !== 1'b0) begin
         nfail++;
         $display("FAIL reset_mid_pre: tx=%b expected 0", tx);
      end
      reset = 1'b1;
      #1;
      ncmp++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         nfail++;
         $display("FAIL reset_mid_async: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
                  tx, busy, done);
      end
      step();
      step();
      reset = 1'b0;
      check_idle(W, "reset_mid_no_done");
      run_word(24'h000001, 1'b0, -1, '0, 1'b0, -1, "after_reset");
      step();
   endtask

   task automatic test_back_to_back();
      run_word(24'h0000FF, 1'b1, -1, '0, 1'b0, -1, "b2b_first");
      run_word(24'h0000FF, 1'b0, -1, '0, 1'b0, -1, "b2b_second");
      step();
      check_idle(3, "b2b_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_word(24'($urandom()), 1'b0, int'($urandom_range(1, W - 2)), 24'($urandom()),
                  1'b1, -1, "random");
         repeat ($urandom_range(1, 4)) step();
      end
      check_idle(2, "random_after");
   endtask

   initial begin
      test_reset();
      test_single();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
